// File: rtl/layer_header_regfile.sv
// Layer-header register file: wide registered pipeline read port, narrow controller port and a clear engine.
// Define SHADOW_COMMIT_EN to split storage into shadow (controller) and active (pipeline) banks.
module layer_header_regfile #(
    parameter int NUM_LAYERS = 32,
    parameter int NUM_REGS   = 8,
    parameter int REG_W      = 16,
    localparam int LAYER_AW  = $clog2(NUM_LAYERS),
    localparam int REG_AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_rd_en,
    input  logic [LAYER_AW-1:0]       pipe_layer,
    output logic [NUM_REGS*REG_W-1:0] pipe_info,
    output logic                      pipe_valid,
    input  logic [LAYER_AW-1:0]       ctrl_layer,
    input  logic [REG_AW-1:0]         ctrl_reg,
    input  logic                      ctrl_wr_en,
    input  logic [REG_W-1:0]          ctrl_wr_data,
    input  logic                      ctrl_rd_en,
    output logic [REG_W-1:0]          ctrl_rd_data,
    output logic                      ctrl_rd_valid,
    input  logic                      clr_req,
    input  logic                      clr_all,
    input  logic [LAYER_AW-1:0]       clr_layer,
    output logic                      busy,
    input  logic                      commit
);
    typedef enum logic [1:0] {IDLE, CLR_ONE, CLR_ALL} state_t;

    state_t                    state_q;
    logic [LAYER_AW-1:0]       clr_idx_q;
    logic                      busy_q;
    logic [NUM_REGS*REG_W-1:0] pipe_info_q, pipe_info_d;
    logic                      pipe_valid_q;
    logic [REG_W-1:0]          ctrl_rd_data_q, ctrl_rd_data_d;
    logic                      ctrl_rd_valid_q;
    logic                      pipe_lay_ok, ctrl_lay_ok, clr_lay_ok, ctrl_reg_ok;
    logic                      ctrl_in_rng, wr_ok;

    logic [REG_W-1:0] shd_q [NUM_LAYERS][NUM_REGS];
`ifdef SHADOW_COMMIT_EN
    logic [REG_W-1:0] act_q [NUM_LAYERS][NUM_REGS];
    logic             commit_pend_q;
    logic             do_commit;
    assign do_commit = !busy_q && (commit || commit_pend_q);
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

    // Range checks collapse to constants when the index width exactly spans the array.
    if (NUM_LAYERS == (1 << LAYER_AW)) begin : g_lay_full
        assign pipe_lay_ok = 1'b1;
        assign ctrl_lay_ok = 1'b1;
        assign clr_lay_ok  = 1'b1;
    end else begin : g_lay_part
        assign pipe_lay_ok = 32'(pipe_layer) < NUM_LAYERS;
        assign ctrl_lay_ok = 32'(ctrl_layer) < NUM_LAYERS;
        assign clr_lay_ok  = 32'(clr_idx_q) < NUM_LAYERS;
    end
    if (NUM_REGS == (1 << REG_AW)) begin : g_reg_full
        assign ctrl_reg_ok = 1'b1;
    end else begin : g_reg_part
        assign ctrl_reg_ok = 32'(ctrl_reg) < NUM_REGS;
    end

    assign ctrl_in_rng = ctrl_lay_ok && ctrl_reg_ok;
    assign wr_ok       = ctrl_wr_en && !busy_q && ctrl_in_rng;

    always_comb begin
        pipe_info_d    = '0;
        ctrl_rd_data_d = '0;
        if (pipe_lay_ok) begin
            for (int k = 0; k < NUM_REGS; k++) begin
`ifdef SHADOW_COMMIT_EN
                pipe_info_d[k*REG_W +: REG_W] = act_q[pipe_layer][k];
`else
                pipe_info_d[k*REG_W +: REG_W] = shd_q[pipe_layer][k];
`endif
            end
        end
        if (ctrl_in_rng) ctrl_rd_data_d = shd_q[ctrl_layer][ctrl_reg];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q   <= clr_all ? CLR_ALL : CLR_ONE;
                        clr_idx_q <= clr_all ? '0 : clr_layer;
                        busy_q    <= 1'b1;
                    end
                end
                CLR_ONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                CLR_ALL: begin
                    if (clr_idx_q == LAYER_AW'(NUM_LAYERS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Writes never collide with clears: controller writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shd_q <= '{default: '0};
`ifdef SHADOW_COMMIT_EN
            act_q         <= '{default: '0};
            commit_pend_q <= 1'b0;
`endif
        end else begin
`ifdef SHADOW_COMMIT_EN
            if (do_commit) act_q <= shd_q;
            if (busy_q) begin
                if (commit) commit_pend_q <= 1'b1;
            end else begin
                commit_pend_q <= 1'b0;
            end
`endif
            if (wr_ok) begin
                shd_q[ctrl_layer][ctrl_reg] <= ctrl_wr_data;
`ifdef SHADOW_COMMIT_EN
                if (do_commit) act_q[ctrl_layer][ctrl_reg] <= ctrl_wr_data;
`endif
            end
            if (busy_q && clr_lay_ok) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    shd_q[clr_idx_q][r] <= '0;
`ifdef SHADOW_COMMIT_EN
                    act_q[clr_idx_q][r] <= '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_info_q     <= '0;
            pipe_valid_q    <= 1'b0;
            ctrl_rd_data_q  <= '0;
            ctrl_rd_valid_q <= 1'b0;
        end else begin
            pipe_valid_q    <= pipe_rd_en;
            ctrl_rd_valid_q <= ctrl_rd_en;
            if (pipe_rd_en) pipe_info_q    <= pipe_info_d;
            if (ctrl_rd_en) ctrl_rd_data_q <= ctrl_rd_data_d;
        end
    end

    assign pipe_info     = pipe_info_q;
    assign pipe_valid    = pipe_valid_q;
    assign ctrl_rd_data  = ctrl_rd_data_q;
    assign ctrl_rd_valid = ctrl_rd_valid_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_layer_header_regfile.sv
// Scoreboard bench for layer_header_regfile: a behavioural model queues expected responses, a monitor checks them.
module tb_layer_header_regfile;
    localparam int NL  = 32;
    localparam int NR  = 8;
    localparam int RW  = 16;
    localparam int LAW = $clog2(NL);
    localparam int RAW = (NR > 1) ? $clog2(NR) : 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              pipe_rd_en;
    logic [LAW-1:0]    pipe_layer;
    logic [NR*RW-1:0]  pipe_info;
    logic              pipe_valid;
    logic [LAW-1:0]    ctrl_layer;
    logic [RAW-1:0]    ctrl_reg;
    logic              ctrl_wr_en;
    logic [RW-1:0]     ctrl_wr_data;
    logic              ctrl_rd_en;
    logic [RW-1:0]     ctrl_rd_data;
    logic              ctrl_rd_valid;
    logic              clr_req;
    logic              clr_all;
    logic [LAW-1:0]    clr_layer;
    logic              busy;
    logic              commit;

    always #5 clk = ~clk;

    layer_header_regfile #(.NUM_LAYERS(NL), .NUM_REGS(NR), .REG_W(RW)) dut (
        .clk(clk), .reset(reset),
        .pipe_rd_en(pipe_rd_en), .pipe_layer(pipe_layer), .pipe_info(pipe_info), .pipe_valid(pipe_valid),
        .ctrl_layer(ctrl_layer), .ctrl_reg(ctrl_reg), .ctrl_wr_en(ctrl_wr_en), .ctrl_wr_data(ctrl_wr_data),
        .ctrl_rd_en(ctrl_rd_en), .ctrl_rd_data(ctrl_rd_data), .ctrl_rd_valid(ctrl_rd_valid),
        .clr_req(clr_req), .clr_all(clr_all), .clr_layer(clr_layer), .busy(busy), .commit(commit)
    );

    int checks = 0;
    int failures = 0;

    logic [NR*RW-1:0] exp_pipe_q [$];
    logic [RW-1:0]    exp_ctrl_q [$];
    bit               exp_busy_q [$];

    // Reference model: m_shd is the controller-visible bank (the only bank without the shadow feature).
    logic [RW-1:0] m_shd [NL][NR];
    logic [RW-1:0] m_act [NL][NR];
    int            clr_list [$];
    bit            pend;

    function automatic logic [NR*RW-1:0] pipe_expect(input int l);
        logic [NR*RW-1:0] v;
        v = '0;
        if (l < NL) begin
            for (int k = 0; k < NR; k++) begin
`ifdef SHADOW_COMMIT_EN
                v[k*RW +: RW] = m_act[l][k];
`else
                v[k*RW +: RW] = m_shd[l][k];
`endif
            end
        end
        return v;
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int l = 0; l < NL; l++)
                for (int r = 0; r < NR; r++) begin
                    m_shd[l][r] = '0;
                    m_act[l][r] = '0;
                end
            clr_list.delete();
            pend = 0;
        end else if (clr_list.size() != 0) begin
            int l;
            l = clr_list.pop_front();
            if (l < NL)
                for (int r = 0; r < NR; r++) begin
                    m_shd[l][r] = '0;
                    m_act[l][r] = '0;
                end
            if (commit) pend = 1;
        end else begin
            if (ctrl_wr_en && int'(ctrl_layer) < NL && int'(ctrl_reg) < NR)
                m_shd[ctrl_layer][ctrl_reg] = ctrl_wr_data;
            if (commit || pend) m_act = m_shd;
            pend = 0;
            if (clr_req) begin
                if (clr_all) begin
                    for (int l = 0; l < NL; l++) clr_list.push_back(l);
                end else begin
                    clr_list.push_back(int'(clr_layer));
                end
            end
        end
    endtask

    task automatic step();
        logic [NR*RW-1:0] ep;
        logic [RW-1:0]    ec;
        bit               dp, dc;
        dp = !reset && pipe_rd_en;
        dc = !reset && ctrl_rd_en;
        ep = pipe_expect(int'(pipe_layer));
        ec = (int'(ctrl_layer) < NL && int'(ctrl_reg) < NR) ? m_shd[ctrl_layer][ctrl_reg] : '0;
        @(posedge clk);
        if (dp) exp_pipe_q.push_back(ep);
        if (dc) exp_ctrl_q.push_back(ec);
        model_edge();
        exp_busy_q.push_back(clr_list.size() != 0);
        #1;
    endtask

    task automatic idle();
        pipe_rd_en = 0; ctrl_wr_en = 0; ctrl_rd_en = 0;
        clr_req = 0; clr_all = 0; commit = 0;
    endtask

    task automatic wr(input int l, input int r, input logic [RW-1:0] d);
        idle();
        ctrl_wr_en = 1; ctrl_layer = LAW'(l); ctrl_reg = RAW'(r); ctrl_wr_data = d;
        step();
    endtask

    task automatic rd(input int l, input int r);
        idle();
        ctrl_rd_en = 1; ctrl_layer = LAW'(l); ctrl_reg = RAW'(r);
        pipe_rd_en = 1; pipe_layer = LAW'(l);
        step();
    endtask

    task automatic chk(input string name, input logic [NR*RW-1:0] act, input logic [NR*RW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_busy_q.size() > 0) begin
            bit eb;
            eb = exp_busy_q.pop_front();
            chk("busy", {{(NR*RW-1){1'b0}}, busy}, {{(NR*RW-1){1'b0}}, eb});
        end
        if (exp_pipe_q.size() > 0) begin
            logic [NR*RW-1:0] e;
            e = exp_pipe_q.pop_front();
            chk("pipe_valid", {{(NR*RW-1){1'b0}}, pipe_valid}, {{(NR*RW-1){1'b0}}, 1'b1});
            chk("pipe_info", pipe_info, e);
        end else if (pipe_valid !== 1'b0 && reset === 1'b0) begin
            chk("pipe_valid_spurious", {{(NR*RW-1){1'b0}}, pipe_valid}, '0);
        end
        if (exp_ctrl_q.size() > 0) begin
            logic [RW-1:0] e;
            e = exp_ctrl_q.pop_front();
            chk("ctrl_rd_valid", {{(NR*RW-1){1'b0}}, ctrl_rd_valid}, {{(NR*RW-1){1'b0}}, 1'b1});
            chk("ctrl_rd_data", {{(NR*RW-RW){1'b0}}, ctrl_rd_data}, {{(NR*RW-RW){1'b0}}, e});
        end else if (ctrl_rd_valid !== 1'b0 && reset === 1'b0) begin
            chk("ctrl_rd_valid_spurious", {{(NR*RW-1){1'b0}}, ctrl_rd_valid}, '0);
        end
    end

    initial begin
        idle();
        reset = 1; pipe_layer = '0; ctrl_layer = '0; ctrl_reg = '0; ctrl_wr_data = '0; clr_layer = '0;
        step(); step();
        reset = 0;
        chk("reset_pipe_info", pipe_info, '0);
        chk("reset_ctrl_rd_data", {{(NR*RW-RW){1'b0}}, ctrl_rd_data}, '0);
        chk("reset_flags", {{(NR*RW-3){1'b0}}, pipe_valid, ctrl_rd_valid, busy}, '0);

        idle(); pipe_rd_en = 1; pipe_layer = LAW'(5); step();
        wr(3, 2, 16'hBEEF);
        rd(3, 2);
        idle(); step();

        for (int r = 0; r < NR; r++) wr(7, r, RW'((r + 1) * 16'h1111));
        for (int r = 0; r < NR; r++) wr(6, r, RW'(16'h0600 + r));
        idle(); clr_req = 1; clr_all = 0; clr_layer = LAW'(7); step();
        idle(); step(); step();
        for (int r = 0; r < NR; r++) rd(7, r);
        for (int r = 0; r < NR; r++) rd(6, r);

        for (int l = 0; l < NL; l++)
            for (int r = 0; r < NR; r++) wr(l, r, RW'($urandom));
        idle(); clr_req = 1; clr_all = 1; step();
        wr(4, 1, 16'hDEAD);
        idle(); pipe_rd_en = 1; pipe_layer = LAW'(20); step();
        for (int i = 0; i < NL + 2; i++) begin idle(); step(); end
        for (int l = 0; l < NL; l++) rd(l, l % NR);

        wr(2, 0, 16'h0001);
        idle(); ctrl_wr_en = 1; ctrl_layer = LAW'(2); ctrl_reg = '0; ctrl_wr_data = 16'h0002;
        pipe_rd_en = 1; pipe_layer = LAW'(2); step();
        rd(2, 0);

        wr(9, 3, 16'h1234);
        idle(); ctrl_wr_en = 1; ctrl_layer = LAW'(9); ctrl_reg = RAW'(3); ctrl_wr_data = 16'h5678;
        clr_req = 1; clr_all = 0; clr_layer = LAW'(9); step();
        idle(); step();
        rd(9, 3);

        wr(0, 0, 16'h00AA);
        rd(0, 0);
        idle(); commit = 1; step();
        rd(0, 0);

        idle(); clr_req = 1; clr_all = 1; step();
        idle(); commit = 1; step();
        idle(); step(); step();
        reset = 1; step();
        reset = 0; idle(); step();
        rd(0, 0);

        for (int i = 0; i < 2500; i++) begin
            idle();
            pipe_rd_en   = 1'($urandom_range(0, 1));
            pipe_layer   = LAW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NL - 1) : $urandom_range(0, 3));
            ctrl_rd_en   = 1'($urandom_range(0, 1));
            ctrl_wr_en   = 1'($urandom_range(0, 1));
            ctrl_layer   = LAW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NL - 1) : $urandom_range(0, 3));
            ctrl_reg     = RAW'($urandom_range(0, NR - 1));
            ctrl_wr_data = RW'($urandom);
            clr_req      = ($urandom_range(0, 59) == 0);
            clr_all      = ($urandom_range(0, 3) == 0);
            clr_layer    = LAW'($urandom_range(0, 3));
            commit       = ($urandom_range(0, 7) == 0);
            reset        = ($urandom_range(0, 699) == 0);
            step();
            reset = 0;
        end

        idle(); step(); step();
        @(negedge clk); #1;
        chk("queues_drained", NR*RW'(exp_pipe_q.size() + exp_ctrl_q.size() + exp_busy_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_header_regfile.md
Name: layer_header_regfile

Overview:
Parametrised layer-header register file for the GPU layer pipeline stage 1. It holds NUM_LAYERS headers of NUM_REGS registers each, REG_W bits per register. It serves two clients: a wide registered read port for the pixel pipeline, and a narrow read/write port for the controller. A sequenced clear engine wipes one layer or all layers, one layer per cycle, reporting busy.

Parameters:
NUM_LAYERS, 32, number of layer headers (>=2)
NUM_REGS, 8, registers per layer header (>=1)
REG_W, 16, bits per register
LAYER_AW, $clog2(NUM_LAYERS), layer index width (derived, localparam)
REG_AW, $clog2(NUM_REGS) min 1, register index width (derived, localparam)

Ports:
clk  in  1  GPU clock
reset  in  1  synchronous, active-high reset
pipe_rd_en  in  1  pipeline read request
pipe_layer  in  LAYER_AW  layer to read for pipeline
pipe_info  out  NUM_REGS*REG_W  full header; reg k at [k*REG_W +: REG_W]
pipe_valid  out  1  pipe_info valid (1 cycle after pipe_rd_en)
ctrl_layer  in  LAYER_AW  controller layer index
ctrl_reg  in  REG_AW  controller register index
ctrl_wr_en  in  1  controller write strobe
ctrl_wr_data  in  REG_W  controller write data
ctrl_rd_en  in  1  controller read strobe
ctrl_rd_data  out  REG_W  controller read data
ctrl_rd_valid  out  1  ctrl_rd_data valid (1 cycle after ctrl_rd_en)
clr_req  in  1  start clear (pulse)
clr_all  in  1  sampled with clr_req: 1 = all layers, 0 = clr_layer only
clr_layer  in  LAYER_AW  layer to clear when clr_all=0
busy  out  1  clear engine active
commit  in  1  frame-boundary commit (used only with SHADOW_COMMIT_EN)

Behaviour:
- Reset: every register = 0; pipe_info = 0, pipe_valid = 0, ctrl_rd_data = 0, ctrl_rd_valid = 0, busy = 0, FSM = IDLE. Reset mid-clear aborts the sequence; the array is zero regardless.
- Pipe read: latency 1. pipe_info/pipe_valid update on the edge after pipe_rd_en=1. pipe_info holds its value when pipe_rd_en=0; pipe_valid is then 0. Reads are never stalled by busy.
- Ctrl read: latency 1 with the same hold rule. Result is the register at {ctrl_layer, ctrl_reg}.
- Ctrl write: data is written on the edge where ctrl_wr_en=1 and busy=0. The write is dropped while busy=1.
- Read-during-write to the same address returns the OLD value (both ports).
- Out of range: ctrl_layer or pipe_layer >= NUM_LAYERS, or ctrl_reg >= NUM_REGS, reads 0 and writes are ignored.
- Clear FSM states: IDLE, CLR_ONE, CLR_ALL.
  - IDLE: clr_req with clr_all=0 -> CLR_ONE, latching clr_layer. clr_req with clr_all=1 -> CLR_ALL, with the counter at 0.
  - CLR_ONE: zeroes all NUM_REGS registers of the latched layer in 1 cycle -> IDLE.
  - CLR_ALL: zeroes layer[counter] each cycle and increments the counter. After layer NUM_LAYERS-1 -> IDLE. Total NUM_LAYERS cycles; no wrap.
  - busy = (state != IDLE), registered. It rises the cycle after clr_req and falls the cycle after the last clear write.
  - clr_req while busy is ignored.
- Simultaneous events:
  - clr_req and ctrl_wr_en in the same cycle while IDLE: the write completes first and the clear then starts, so a write to the cleared layer ends up 0.
  - Pipe read of the layer being cleared in the same cycle returns pre-clear data.

Optional Feature:
SHADOW_COMMIT_EN
- Defined: two banks, shadow and active. Ctrl writes and ctrl reads target shadow; pipe reads target active. When commit=1 and busy=0, shadow is copied to active in one edge. If a ctrl write and commit occur on the same edge, the write is included in the copy. Clear writes zero both banks. A commit while busy is deferred until the cycle busy falls.
- Undefined: single bank; commit is ignored; ctrl writes are visible to pipe reads on the next cycle.

Test Plan:
- Reset, then pipe_rd_en on layer 5 -> pipe_info=0, pipe_valid=1 one cycle later.
- Write 0xBEEF to layer 3 reg 2, then ctrl read -> ctrl_rd_data=0xBEEF at latency 1. Pipe read of layer 3 -> bits[47:32]=0xBEEF.
- Write layer 7 regs 0..7 = 0x1111..0x8888. Pulse clr_req, clr_all=0, clr_layer=7 -> busy high for exactly 1 cycle; layer 7 reads all 0; layer 6 is unchanged.
- Fill all layers, then clr_all=1 -> busy high for 32 cycles. A ctrl write during busy is dropped; all reads are 0 afterwards.
- Ctrl write and pipe read to layer 2 reg 0 in the same cycle (old=0x0001, new=0x0002) -> pipe sees 0x0001; the next read sees 0x0002 (without the macro).
- With SHADOW_COMMIT_EN: write 0x00AA -> pipe still reads 0. Pulse commit -> the next pipe read returns 0x00AA.
